ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Round-robin arbiter that shares one single-port-access synchronous `ram` instance between NUM_REQ requesters.
- Typical requesters: the label writer, the merge-table updater and the readout path of the detection pipeline.
- Per cycle, it grants at most one requester, steers that requester's address, write-enable and write data onto the RAM ports, and returns read data with a registered valid strobe one cycle later.
- It supports locked bursts, so one requester can hold the RAM for consecutive accesses.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2..16.
- ADDR_WIDTH, 8, RAM address width; matches the `ram` instance.
- DATA_WIDTH, 32, RAM data width; matches the `ram` instance.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request. Level-sensitive; held until gnt.
- lock  in  NUM_REQ  per-requester burst lock; qualified by req.
- we  in  NUM_REQ  per-requester write enable; 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_REQ*DATA_WIDTH  packed write data; same packing.
- gnt  out  NUM_REQ  one-hot grant, combinational. The access completes in any cycle where req[i] & gnt[i].
- rvalid  out  NUM_REQ  registered one-hot strobe, high one cycle after a granted read.
- rdata  out  DATA_WIDTH  shared read data; valid only with rvalid.
- ram_wen  out  1  to ram.wen.
- ram_w_addr  out  ADDR_WIDTH  to ram.w_addr.
- ram_r_addr  out  ADDR_WIDTH  to ram.r_addr.
- ram_data_in  out  DATA_WIDTH  to ram.data_in.
- ram_data_out  in  DATA_WIDTH  from ram.data_out.

Behaviour:
- Reset (async assert, sync release):
  - ptr=0, owner_valid=0, rvalid=0.
  - While reset_n=0: gnt=0 and ram_wen=0.
- Arbitration is combinational from req, registered ptr and owner state:
  - If owner_valid and req[owner]: gnt = one-hot(owner). This is the locked-burst hold; other requesters are ignored.
  - Else the first i with req[i]=1, scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1, is granted.
  - No req: gnt=0.
- State update on each grant to requester g (same clock edge):
  - ptr <= (g+1) mod NUM_REQ, with wrap at NUM_REQ-1 -> 0.
  - owner <= g and owner_valid <= lock[g].
  - A grant with lock[g]=0 ends the burst; the last access of a burst carries lock=0.
  - If req[owner] drops while owner_valid=1: owner_valid <= 0 and normal round-robin resumes the same cycle.
- RAM steering (combinational):
  - ram_w_addr = ram_r_addr = addr[g], ram_data_in = wdata[g], ram_wen = we[g] & |gnt.
  - With no grant, the address and data outputs hold requester 0's fields and ram_wen=0.
- Read return:
  - On a granted read: rvalid <= gnt (one-hot) next cycle, else rvalid <= 0.
  - rdata = ram_data_out, passed straight through.
  - Read latency is exactly 1 cycle from the grant cycle.
- Granted writes: data lands in ram at the grant edge and produces no rvalid.
- Back-to-back: one access per cycle sustained. A requester may keep req high to issue consecutive accesses, subject to round-robin when unlocked.
- Read after write: a read granted the cycle after a write to the same address returns the new data. Only one access per cycle, so no same-cycle collision exists.
- Fairness: with all req high and lock=0, grants rotate 0,1,...,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 grants plus any burst length.
- Reset mid-burst: owner_valid cleared and ptr=0. A pending rvalid is dropped, and the requester must reissue.

Decomposition:
- global.vh: no new shared constants; clog2 of NUM_REQ is computed locally as a localparam.
- Sub-module rr_pick: purely combinational masked priority encoder; inputs req and ptr, output one-hot gnt and index.
- ram_arbiter owns ptr, owner, owner_valid, rvalid and the steering muxes. The `ram` stays outside, instantiated alongside by the parent.

Test Plan:
- Reset mid-operation: assert reset_n=0 during a locked burst -> gnt=0, rvalid=0, ram_wen=0 immediately. After release, req=4'b0110 grants requester 1 first (ptr=0).
- Single requester write then read: req[2]=1, we=1, addr=8'h10, wdata=32'hDEADBEEF for one cycle, then we=0 -> gnt=4'b0100 both cycles. rvalid=4'b0100 with rdata=32'hDEADBEEF one cycle after the read grant.
- All four requesting continuously, lock=0 -> gnt sequence 0001,0010,0100,1000,0001. Each read's rvalid trails its grant by exactly 1 cycle.
- Locked burst: requester 1 holds lock=1 for 3 reads (addr 0,1,2) while req=4'b1111, then lock=0 on the 4th -> gnt=4'b0010 for 4 consecutive cycles, then 4'b0100.
- Wrap-around: ptr at 3, only req[1] and req[3] set -> grant 3, then grant 1 (ptr wraps to 0 and scans up).
- Burst abandoned: requester 0 locked, drops req mid-burst while req[3]=1 -> requester 3 is granted in the same cycle and owner_valid is cleared.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: the debug view of the arbitration state.
package ram_arbiter_pkg;

   // Wide enough for the largest supported NUM_REQ (16).
   localparam int DBG_IDX_W = 4;

   typedef struct packed {
      logic [DBG_IDX_W-1:0] ptr;
      logic [DBG_IDX_W-1:0] owner;
      logic                 owner_valid;
   } arb_dbg_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter, one lane per requester.
interface ram_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   // Handshake: requester i holds req[i], lock[i], we[i] and its addr/wdata lanes
   // stable until it sees gnt[i]; the access completes in any cycle with
   // req[i] & gnt[i]. A completed read returns rdata qualified by rvalid[i] one
   // cycle later; a completed write returns nothing.
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ-1:0]            we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;

   modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module ram_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   // One extra bit so ptr + offset never overflows before the wrap subtract.
   logic [IDX_W:0] pos;
   logic           found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(NUM_REQ)) begin
            pos = pos - (IDX_W+1)'(NUM_REQ);
         end
         if (!found && req[pos[IDX_W-1:0]]) begin
            found                 = 1'b1;
            gnt[pos[IDX_W-1:0]] = 1'b1;
            idx                   = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between NUM_REQ requesters,
// with locked bursts and a registered one-hot read-valid strobe.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   ram_arbiter_if.slave          bus,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_w_addr,
   output logic [ADDR_WIDTH-1:0] ram_r_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output arb_dbg_t              dbg
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   owner;
   logic               owner_valid;
   logic [NUM_REQ-1:0] rvalid_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] gnt_int;
   logic [IDX_W-1:0]   g_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               hold;
   logic               any_gnt;

   ram_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req (bus.req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // A locked owner that still requests wins outright; once it drops req the
   // round-robin pick takes over in the same cycle.
   assign hold = owner_valid & bus.req[owner];

   always_comb begin
      gnt_int = pick_gnt;
      g_idx   = pick_idx;
      if (hold) begin
         gnt_int = NUM_REQ'(1) << owner;
         g_idx   = owner;
      end
   end

   assign bus.gnt = reset_n ? gnt_int : '0;
   assign any_gnt = |bus.gnt;

   // Idle cycles park the RAM ports on requester 0's lanes.
   assign sel_idx     = any_gnt ? g_idx : '0;
   assign ram_w_addr  = bus.addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign ram_r_addr  = ram_w_addr;
   assign ram_data_in = bus.wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
   assign ram_wen     = bus.we[sel_idx] & any_gnt;

   assign bus.rdata  = ram_data_out;
   assign bus.rvalid = rvalid_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr         <= '0;
         owner       <= '0;
         owner_valid <= 1'b0;
         rvalid_q    <= '0;
      end else if (any_gnt) begin
         ptr         <= (g_idx == IDX_W'(NUM_REQ-1)) ? '0 : g_idx + IDX_W'(1);
         owner       <= g_idx;
         owner_valid <= bus.lock[g_idx];
         rvalid_q    <= bus.we[g_idx] ? '0 : bus.gnt;
      end else begin
         owner_valid <= 1'b0;
         rvalid_q    <= '0;
      end
   end

   always_comb begin
      dbg             = '0;
      dbg.ptr         = DBG_IDX_W'(ptr);
      dbg.owner       = DBG_IDX_W'(owner);
      dbg.owner_valid = owner_valid;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural synchronous RAM beside it.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   logic          ram_wen;
   logic [AW-1:0] ram_w_addr;
   logic [AW-1:0] ram_r_addr;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   arb_dbg_t      dbg;

   ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .ram_wen      (ram_wen),
      .ram_w_addr   (ram_w_addr),
      .ram_r_addr   (ram_r_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .dbg          (dbg)
   );

   // Synchronous single-port RAM: write lands at the edge, read data registered.
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (ram_wen) mem[ram_w_addr] <= ram_data_in;
      ram_data_out <= mem[ram_r_addr];
   end

   logic [DW-1:0]    shadow [256];
   logic [NR+DW-1:0] exp_q [$];
   logic [NR+DW-1:0] sb_e;
   int n_pass = 0;
   int n_total = 0;

   // One expectation per driven cycle: {rvalid one-hot, rdata} due after that edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) sb_e = exp_q.pop_front();
      else sb_e = '0;
      n_total++;
      if (bus.rvalid === sb_e[NR+DW-1:DW]) n_pass++;
      else $display("FAIL rvalid: got %b want %b at %0t", bus.rvalid, sb_e[NR+DW-1:DW], $time);
      if (sb_e[NR+DW-1:DW] != '0) begin
         n_total++;
         if (bus.rdata === sb_e[DW-1:0]) n_pass++;
         else $display("FAIL rdata: got %h want %h at %0t", bus.rdata, sb_e[DW-1:0], $time);
      end
   end

   task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic [NR-1:0] w,
                        input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
      @(negedge clk);
      bus.req   = r;
      bus.lock  = l;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      #1;
   endtask

   // Model the access the bench expects this cycle (g < 0: no grant).
   task automatic model_access(input int g);
      logic [AW-1:0] a;
      if (g < 0) begin
         exp_q.push_back('0);
      end else begin
         a = bus.addr[g*AW +: AW];
         if (bus.we[g]) begin
            shadow[a] = bus.wdata[g*DW +: DW];
            exp_q.push_back('0);
         end else begin
            exp_q.push_back({NR'(1 << g), shadow[a]});
         end
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      bus.req   = '1;
      bus.lock  = '0;
      bus.we    = '1;
      bus.addr  = '0;
      bus.wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else n_pass++;
      n_total++;
      if (ram_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", ram_wen); else n_pass++;
      n_total++;
      if (dbg !== arb_dbg_t'('0)) $display("FAIL reset_dbg: got %h want 0", dbg); else n_pass++;
      bus.req = '0;
      bus.we  = '0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_preload();
      for (int i = 0; i < 16; i++) begin
         drive(4'b0001, 4'b0000, 4'b0001, {24'h0, 8'(i)}, {96'h0, 32'($urandom())});
         n_total++;
         if (bus.gnt !== 4'b0001) $display("FAIL preload_gnt: got %b want 0001", bus.gnt); else n_pass++;
         model_access(0);
      end
   endtask

   task automatic test_write_read();
      drive(4'b0100, 4'b0000, 4'b0100, {8'h0, 8'h10, 16'h0}, {32'h0, 32'hDEADBEEF, 64'h0});
      n_total++;
      if (bus.gnt !== 4'b0100) $display("FAIL wr_gnt: got %b want 0100", bus.gnt); else n_pass++;
      n_total++;
      if ({ram_wen, ram_w_addr, ram_data_in} !== {1'b1, 8'h10, 32'hDEADBEEF})
         $display("FAIL wr_ram: got %b %h %h want 1 10 deadbeef", ram_wen, ram_w_addr, ram_data_in);
      else n_pass++;
      model_access(2);
      drive(4'b0100, 4'b0000, 4'b0000, {8'h0, 8'h10, 16'h0}, '0);
      n_total++;
      if (bus.gnt !== 4'b0100 || ram_wen !== 1'b0)
         $display("FAIL rd_gnt: got %b wen %b want 0100 wen 0", bus.gnt, ram_wen);
      else n_pass++;
      model_access(2);
      drive(4'b0000, 4'b0000, 4'b0001, {24'h0, 8'h33}, '0);
      n_total++;
      if ({bus.gnt, ram_wen, ram_w_addr} !== {4'b0000, 1'b0, 8'h33})
         $display("FAIL idle_park: got %b %b %h want 0000 0 33", bus.gnt, ram_wen, ram_w_addr);
      else n_pass++;
      model_access(-1);
   endtask

   task automatic test_round_robin();
      logic [NR-1:0]    seq [5];
      int               who [5];
      logic [NR-1:0]    w;
      logic [NR*AW-1:0] a;
      logic [NR*DW-1:0] d;
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      who = '{0, 1, 2, 3, 0};
      drive(4'b1000, 4'b0000, 4'b0000, {8'h05, 24'h0}, '0);
      n_total++;
      if (bus.gnt !== 4'b1000) $display("FAIL rr_align: got %b want 1000", bus.gnt); else n_pass++;
      model_access(3);
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < NR; i++) begin
            a[i*AW +: AW] = AW'($urandom_range(0, 15));
            d[i*DW +: DW] = DW'($urandom());
         end
         w = NR'($urandom_range(0, 15));
         drive(4'b1111, 4'b0000, w, a, d);
         n_total++;
         if (bus.gnt !== seq[c]) $display("FAIL rr_gnt%0d: got %b want %b", c, bus.gnt, seq[c]);
         else n_pass++;
         model_access(who[c]);
      end
   endtask

   task automatic test_locked_burst();
      for (int c = 0; c < 4; c++) begin
         drive(4'b1111, (c < 3) ? 4'b0010 : 4'b0000, 4'b0000, {16'h0, 8'(c), 8'h0}, '0);
         n_total++;
         if (bus.gnt !== 4'b0010) $display("FAIL burst_gnt%0d: got %b want 0010", c, bus.gnt);
         else n_pass++;
         model_access(1);
      end
      drive(4'b1111, 4'b0000, 4'b0000, {8'h0, 8'h07, 16'h0}, '0);
      n_total++;
      if (bus.gnt !== 4'b0100) $display("FAIL burst_end: got %b want 0100", bus.gnt); else n_pass++;
      model_access(2);
   endtask

   task automatic test_wrap();
      drive(4'b1010, 4'b0000, 4'b0000, {8'h07, 8'h0, 8'h06, 8'h0}, '0);
      n_total++;
      if (dbg.ptr !== 4'd3 || bus.gnt !== 4'b1000)
         $display("FAIL wrap_first: got ptr %0d gnt %b want ptr 3 gnt 1000", dbg.ptr, bus.gnt);
      else n_pass++;
      model_access(3);
      drive(4'b1010, 4'b0000, 4'b0000, {8'h07, 8'h0, 8'h06, 8'h0}, '0);
      n_total++;
      if (dbg.ptr !== 4'd0 || bus.gnt !== 4'b0010)
         $display("FAIL wrap_second: got ptr %0d gnt %b want ptr 0 gnt 0010", dbg.ptr, bus.gnt);
      else n_pass++;
      model_access(1);
   endtask

   task automatic test_burst_abandon();
      drive(4'b0001, 4'b0001, 4'b0000, {8'h09, 16'h0, 8'h08}, '0);
      n_total++;
      if (bus.gnt !== 4'b0001) $display("FAIL abandon_start: got %b want 0001", bus.gnt); else n_pass++;
      model_access(0);
      drive(4'b1001, 4'b0001, 4'b0000, {8'h09, 16'h0, 8'h08}, '0);
      n_total++;
      if (dbg.owner_valid !== 1'b1 || bus.gnt !== 4'b0001)
         $display("FAIL abandon_hold: got ov %b gnt %b want ov 1 gnt 0001", dbg.owner_valid, bus.gnt);
      else n_pass++;
      model_access(0);
      drive(4'b1000, 4'b0001, 4'b0000, {8'h09, 16'h0, 8'h08}, '0);
      n_total++;
      if (bus.gnt !== 4'b1000) $display("FAIL abandon_switch: got %b want 1000", bus.gnt); else n_pass++;
      model_access(3);
      drive(4'b0000, 4'b0000, 4'b0000, '0, '0);
      n_total++;
      if (dbg.owner_valid !== 1'b0) $display("FAIL abandon_ov: got %b want 0", dbg.owner_valid); else n_pass++;
      model_access(-1);
   endtask

   task automatic test_reset_mid_burst();
      drive(4'b0100, 4'b0100, 4'b0000, {8'h0, 8'h02, 16'h0}, '0);
      n_total++;
      if (bus.gnt !== 4'b0100) $display("FAIL rst_burst_gnt: got %b want 0100", bus.gnt); else n_pass++;
      model_access(2);
      @(negedge clk);
      reset_n = 1'b0;
      bus.we  = 4'b0100;
      #1;
      exp_q.delete();
      n_total++;
      if ({bus.gnt, bus.rvalid, ram_wen} !== {4'b0000, 4'b0000, 1'b0})
         $display("FAIL rst_mid: got gnt %b rvalid %b wen %b want 0000 0000 0", bus.gnt, bus.rvalid, ram_wen);
      else n_pass++;
      n_total++;
      if (dbg !== arb_dbg_t'('0)) $display("FAIL rst_mid_dbg: got %h want 0", dbg); else n_pass++;
      bus.req  = '0;
      bus.lock = '0;
      bus.we   = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      drive(4'b0110, 4'b0000, 4'b0000, {16'h0, 8'h04, 8'h0}, '0);
      n_total++;
      if (bus.gnt !== 4'b0010) $display("FAIL rst_release_gnt: got %b want 0010", bus.gnt); else n_pass++;
      model_access(1);
   endtask

   initial begin
      bus.req   = '0;
      bus.lock  = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      test_reset();
      test_preload();
      test_write_read();
      test_round_robin();
      test_locked_burst();
      test_wrap();
      test_burst_abandon();
      test_reset_mid_burst();
      repeat (2) begin
         drive('0, '0, '0, '0, '0);
         model_access(-1);
      end
      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
